// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, one-hot output-port constants
// and the route-controller FSM state encoding.
// No ports.
package noc_pkg;

  // Flit type lives in the two MSBs of a flit.
  typedef enum logic [1:0] {
    FlitBody   = 2'b00,
    FlitHead   = 2'b01,
    FlitTail   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

  // One-hot output port, bit order {L,S,N,W,E}.
  localparam logic [4:0] PORT_E = 5'b00001;
  localparam logic [4:0] PORT_W = 5'b00010;
  localparam logic [4:0] PORT_N = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b01000;
  localparam logic [4:0] PORT_L = 5'b10000;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } route_state_e;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY (dimension-ordered) route computation.
// Ports:
//   dest_x_i, dest_y_i : destination coordinates (unsigned, COORD_W bits)
//   port_o             : one-hot output port {L,S,N,W,E}
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned LOCAL_X = 0,
  parameter int unsigned LOCAL_Y = 0
) (
  input  logic [COORD_W-1:0] dest_x_i,
  input  logic [COORD_W-1:0] dest_y_i,
  output logic [4:0]         port_o
);

  localparam logic [COORD_W-1:0] LocalX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LocalY = COORD_W'(LOCAL_Y);

  // X is resolved fully before Y is considered.
  always_comb begin
    port_o = PORT_L;
    if (dest_x_i > LocalX) begin
      port_o = PORT_E;
    end else if (dest_x_i < LocalX) begin
      port_o = PORT_W;
    end else if (dest_y_i > LocalY) begin
      port_o = PORT_N;
    end else if (dest_y_i < LocalY) begin
      port_o = PORT_S;
    end
  end

endmodule

// File: rtl/xy_route_ctrl.sv
// XY route controller sitting between an input FIFO and the switch.
// Pops flits from the FIFO, steers them to a one-hot output port, keeps a
// wormhole lock from head to tail and discards orphan body/tail flits.
// Ports:
//   clk, rst_n (asynchronous, active-high despite the name)
//   fifo_empty, fifo_out, rd_en      : upstream FIFO interface
//   out_flit, out_valid, out_port,
//   out_ready                        : downstream switch interface
//   drop_pulse                       : one-cycle pulse per discarded flit
//   flit_cnt, drop_cnt               : saturating 16-bit counters, present only
//                                      when XY_ROUTE_STATS_EN is defined
module xy_route_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned NUM_BITS = 64,
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned LOCAL_X  = 0,
  parameter int unsigned LOCAL_Y  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [NUM_BITS-1:0] fifo_out,
  output logic                rd_en,
  output logic [NUM_BITS-1:0] out_flit,
  output logic                out_valid,
  output logic [4:0]          out_port,
  input  logic                out_ready,
  output logic                drop_pulse
`ifdef XY_ROUTE_STATS_EN
  ,
  output logic [15:0]         flit_cnt,
  output logic [15:0]         drop_cnt
`endif
);

  route_state_e state_q, state_d;
  logic [4:0]   route_q, route_d;
  logic         lock_q, lock_d;

  flit_type_e   ftype;
  logic         is_route_head;
  logic [4:0]   calc_port;
  logic         in_send, orphan, xfer, advance;

  assign ftype         = flit_type_e'(fifo_out[NUM_BITS-1 -: 2]);
  assign is_route_head = (ftype == FlitHead) || (ftype == FlitSingle);

  xy_route_calc #(
    .COORD_W (COORD_W),
    .LOCAL_X (LOCAL_X),
    .LOCAL_Y (LOCAL_Y)
  ) u_calc (
    .dest_x_i (fifo_out[2*COORD_W-1:COORD_W]),
    .dest_y_i (fifo_out[COORD_W-1:0]),
    .port_o   (calc_port)
  );

  always_comb begin
    in_send    = (state_q == StSend);
    orphan     = in_send && !is_route_head && !lock_q;
    out_valid  = in_send && !orphan;
    out_flit   = fifo_out;
    out_port   = out_valid ? (is_route_head ? calc_port : route_q) : 5'b0;
    drop_pulse = orphan;
    xfer       = out_valid && out_ready;
    // An orphan is consumed as if the downstream had accepted it.
    advance    = xfer || orphan;
    // Reset gates the pop so the FIFO is not drained while held in reset.
    rd_en      = !rst_n && !fifo_empty && (!in_send || advance);

    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = rd_en ? StSend : StIdle;
      StSend:  if (advance) state_d = rd_en ? StSend : StIdle;
      default: state_d = StIdle;
    endcase

    route_d = route_q;
    lock_d  = lock_q;
    if (xfer) begin
      unique case (ftype)
        // A head while locked acts as an implicit tail and re-locks.
        FlitHead: begin
          route_d = calc_port;
          lock_d  = 1'b1;
        end
        FlitTail:   lock_d = 1'b0;
        FlitBody,
        FlitSingle: ;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      route_q <= 5'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      lock_q  <= lock_d;
    end
  end

`ifdef XY_ROUTE_STATS_EN
  logic [15:0] flit_cnt_q, flit_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    flit_cnt_d = flit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (xfer && (flit_cnt_q != 16'hFFFF)) flit_cnt_d = flit_cnt_q + 16'd1;
    if (orphan && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      flit_cnt_q <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      flit_cnt_q <= flit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign flit_cnt = flit_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_xy_route_ctrl.sv
// Directed bench for xy_route_ctrl at LOCAL=(2,1) with a behavioural FIFO.
module tb_xy_route_ctrl;

  localparam int unsigned NB = 64;

  localparam logic [4:0] P_E = 5'b00001;
  localparam logic [4:0] P_W = 5'b00010;
  localparam logic [4:0] P_N = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_L = 5'b10000;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_SING = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty;
  logic [NB-1:0] fifo_out = '0;
  logic          rd_en;
  logic [NB-1:0] out_flit;
  logic          out_valid;
  logic [4:0]    out_port;
  logic          out_ready = 1'b1;
  logic          drop_pulse;
`ifdef XY_ROUTE_STATS_EN
  logic [15:0]   flit_cnt;
  logic [15:0]   drop_cnt;
`endif

  xy_route_ctrl #(
    .NUM_BITS (NB),
    .COORD_W  (4),
    .LOCAL_X  (2),
    .LOCAL_Y  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_out   (fifo_out),
    .rd_en      (rd_en),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_port   (out_port),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse)
`ifdef XY_ROUTE_STATS_EN
    ,
    .flit_cnt   (flit_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data appears on fifo_out the cycle after a pop.
  logic [NB-1:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en && !fifo_empty) begin
      fifo_out <= mem[rd_ptr[6:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Event monitors, sampled with the pre-edge values of the cycle.
  int n_rd = 0, n_xfer = 0, n_drop = 0, bad_rd = 0, bad_port = 0;
  always @(posedge clk) begin
    if (rd_en) n_rd <= n_rd + 1;
    if (rd_en && fifo_empty) bad_rd <= bad_rd + 1;
    if (!out_valid && (out_port != 5'b0)) bad_port <= bad_port + 1;
    if (out_valid && out_ready) n_xfer <= n_xfer + 1;
    if (drop_pulse) n_drop <= n_drop + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input logic [15:0] tag);
    return {t, 38'd0, tag, x, y};
  endfunction

  task automatic push(input logic [NB-1:0] f);
    mem[wr_ptr[6:0]] = f;
    wr_ptr++;
  endtask

  // Waits (bounded) for a transfer, checks it, then moves to the next cycle.
  task automatic expect_xfer(input string tag, input logic [4:0] port,
                             input logic [NB-1:0] flit, output int waited);
    waited = 0;
    #1;
    while (!(out_valid && out_ready) && waited < 12) begin
      step();
      waited++;
    end
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_port"}, 64'(out_port), 64'(port));
    check_eq({tag, "_flit"}, out_flit, flit);
    step();
  endtask

  task automatic expect_drop(input string tag);
    int n;
    n = 0;
    while (!drop_pulse && n < 12) begin
      step();
      n++;
    end
    check_eq({tag, "_drop"}, 64'(drop_pulse), 64'd1);
    check_eq({tag, "_novalid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_noport"}, 64'(out_port), 64'd0);
    step();
    check_eq({tag, "_drop_once"}, 64'(drop_pulse), 64'd0);
  endtask

  initial begin
    int w, r0, x0, d0;
    logic [NB-1:0] f [0:4];
    logic [4:0] ports [0:4];

    // Reset state.
    step();
    step();
    check_eq("rst_rd_en", 64'(rd_en), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_port", 64'(out_port), 64'd0);
    check_eq("rst_drop", 64'(drop_pulse), 64'd0);
    rst_n = 1'b0;
    step();

    // Single flits covering every route direction.
    f[0] = mk(T_SING, 4'd3, 4'd1, 16'h0001); ports[0] = P_E;
    f[1] = mk(T_SING, 4'd0, 4'd3, 16'h0002); ports[1] = P_W;
    f[2] = mk(T_SING, 4'd2, 4'd3, 16'h0003); ports[2] = P_N;
    f[3] = mk(T_SING, 4'd2, 4'd0, 16'h0004); ports[3] = P_S;
    f[4] = mk(T_SING, 4'd2, 4'd1, 16'h0005); ports[4] = P_L;
    for (int i = 0; i < 5; i++) push(f[i]);
    for (int i = 0; i < 5; i++) begin
      expect_xfer($sformatf("single%0d", i), ports[i], f[i], w);
      if (i > 0) check_eq($sformatf("single%0d_b2b", i), 64'(w), 64'd0);
    end

    // Wormhole packet, all flits queued up front.
    f[0] = mk(T_HEAD, 4'd3, 4'd0, 16'h0010);
    f[1] = mk(T_BODY, 4'd0, 4'd0, 16'h0011);
    f[2] = mk(T_BODY, 4'd0, 4'd0, 16'h0012);
    f[3] = mk(T_TAIL, 4'd0, 4'd0, 16'h0013);
    r0 = n_rd;
    for (int i = 0; i < 4; i++) push(f[i]);
    for (int i = 0; i < 4; i++) begin
      expect_xfer($sformatf("pkt%0d", i), P_E, f[i], w);
      if (i > 0) check_eq($sformatf("pkt%0d_b2b", i), 64'(w), 64'd0);
    end
    check_eq("pkt_rd_count", 64'(n_rd - r0), 64'd4);

    // Same packet with a 3-cycle stall on body #1.
    f[0] = mk(T_HEAD, 4'd3, 4'd0, 16'h0020);
    f[1] = mk(T_BODY, 4'd0, 4'd0, 16'h0021);
    f[2] = mk(T_BODY, 4'd0, 4'd0, 16'h0022);
    f[3] = mk(T_TAIL, 4'd0, 4'd0, 16'h0023);
    r0 = n_rd;
    x0 = n_xfer;
    for (int i = 0; i < 4; i++) push(f[i]);
    expect_xfer("stall_head", P_E, f[0], w);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      #1;
      check_eq($sformatf("stall%0d_valid", i), 64'(out_valid), 64'd1);
      check_eq($sformatf("stall%0d_flit", i), out_flit, f[1]);
      check_eq($sformatf("stall%0d_port", i), 64'(out_port), 64'(P_E));
      check_eq($sformatf("stall%0d_rd_en", i), 64'(rd_en), 64'd0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      expect_xfer($sformatf("stall_pkt%0d", i), P_E, f[i], w);
      check_eq($sformatf("stall_pkt%0d_b2b", i), 64'(w), 64'd0);
    end
    check_eq("stall_xfers", 64'(n_xfer - x0), 64'd4);
    check_eq("stall_rd_count", 64'(n_rd - r0), 64'd4);

    // Orphan body: the previous tail must have released the lock.
    d0 = n_drop;
    push(mk(T_BODY, 4'd3, 4'd0, 16'h0030));
    expect_drop("orphan");
    check_eq("orphan_drop_count", 64'(n_drop - d0), 64'd1);
`ifdef XY_ROUTE_STATS_EN
    check_eq("orphan_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Head while locked acts as implicit tail and re-routes the worm.
    f[0] = mk(T_HEAD, 4'd3, 4'd0, 16'h0040); ports[0] = P_E;
    f[1] = mk(T_BODY, 4'd0, 4'd0, 16'h0041); ports[1] = P_E;
    f[2] = mk(T_HEAD, 4'd0, 4'd0, 16'h0042); ports[2] = P_W;
    f[3] = mk(T_BODY, 4'd0, 4'd0, 16'h0043); ports[3] = P_W;
    f[4] = mk(T_TAIL, 4'd0, 4'd0, 16'h0044); ports[4] = P_W;
    for (int i = 0; i < 5; i++) push(f[i]);
    for (int i = 0; i < 5; i++) expect_xfer($sformatf("relock%0d", i), ports[i], f[i], w);
`ifdef XY_ROUTE_STATS_EN
    check_eq("stats_flit_cnt", 64'(flit_cnt), 64'd18);
    check_eq("stats_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Empty FIFO: nothing happens.
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("empty%0d", i), {62'd0, rd_en, out_valid}, 64'd0);
      step();
    end

    // Reset mid-packet clears the lock.
    push(mk(T_HEAD, 4'd3, 4'd0, 16'h0050));
    push(mk(T_BODY, 4'd0, 4'd0, 16'h0051));
    expect_xfer("mid_head", P_E, mk(T_HEAD, 4'd3, 4'd0, 16'h0050), w);
    expect_xfer("mid_body", P_E, mk(T_BODY, 4'd0, 4'd0, 16'h0051), w);
    rst_n = 1'b1;
    push(mk(T_TAIL, 4'd0, 4'd0, 16'h0052));
    push(mk(T_SING, 4'd2, 4'd1, 16'h0053));
    #1;
    check_eq("mid_rst_rd_en", 64'(rd_en), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_port", 64'(out_port), 64'd0);
    check_eq("mid_rst_drop", 64'(drop_pulse), 64'd0);
`ifdef XY_ROUTE_STATS_EN
    check_eq("mid_rst_flit_cnt", 64'(flit_cnt), 64'd0);
`endif
    step();
    check_eq("mid_rst_rd_en_hold", 64'(rd_en), 64'd0);
    rst_n = 1'b0;
    expect_drop("post_rst_tail");
    expect_xfer("post_rst_single", P_L, mk(T_SING, 4'd2, 4'd1, 16'h0053), w);
`ifdef XY_ROUTE_STATS_EN
    check_eq("post_rst_flit_cnt", 64'(flit_cnt), 64'd1);
    check_eq("post_rst_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    step();
    check_eq("never_rd_when_empty", 64'(bad_rd), 64'd0);
    check_eq("no_port_when_invalid", 64'(bad_port), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xy_route_ctrl.md
XY_ROUTE_CTRL -- requirements
Module: xy_route_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 64, flit width; matches the upstream input FIFO data width.
REQ-002 Parameter COORD_W, default 4, width of each mesh coordinate.
REQ-003 Parameter LOCAL_X, default 0, this router's X coordinate.
REQ-004 Parameter LOCAL_Y, default 0, this router's Y coordinate.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-high (asserted = 1).
REQ-007 fifo_empty  input  1  empty flag of the upstream input FIFO.
REQ-008 fifo_out  input  NUM_BITS  FIFO read data; valid the cycle after rd_en is sampled high with fifo_empty low.
REQ-009 rd_en  output  1  pop request to the upstream FIFO.
REQ-010 out_flit  output  NUM_BITS  flit offered downstream.
REQ-011 out_valid  output  1  out_flit is valid.
REQ-012 out_port  output  5  one-hot output port {L,S,N,W,E}, bits [4:0].
REQ-013 out_ready  input  1  downstream switch accepts out_flit this cycle.
REQ-014 drop_pulse  output  1  one-cycle pulse when a flit is discarded.

Function
REQ-015 Flit type is fifo_out[NUM_BITS-1:NUM_BITS-2]: 01 head, 00 body, 10 tail, 11 single (head+tail).
REQ-016 Destination is dest_x = flit[2*COORD_W-1:COORD_W] and dest_y = flit[COORD_W-1:0], decoded only from head and single flits.
REQ-017 XY routing: dest_x>LOCAL_X -> E; dest_x<LOCAL_X -> W; otherwise dest_y>LOCAL_Y -> N; dest_y<LOCAL_Y -> S; otherwise L.
REQ-018 Coordinate comparisons are unsigned over COORD_W bits.
REQ-019 The FSM has two states: IDLE (no flit held) and SEND (flit held on out_flit).
REQ-020 In IDLE, rd_en = !fifo_empty; if rd_en is asserted, the FSM moves to SEND next cycle, otherwise it stays in IDLE.
REQ-021 In SEND, out_valid = 1 and out_flit = fifo_out (pass-through, no extra register).
REQ-022 A transfer occurs when out_valid && out_ready; without a transfer the flit, out_port and state are held unchanged.
REQ-023 In SEND, rd_en = out_ready && !fifo_empty (back-to-back throughput of 1 flit per cycle).
REQ-024 On a SEND transfer with rd_en high, the FSM stays in SEND; with rd_en low, it returns to IDLE.
REQ-025 A head flit computes out_port combinationally from fifo_out; on its transfer, the port is latched into route_reg and lock is set.
REQ-026 Body and tail flits use route_reg while lock=1; a tail transfer clears lock.
REQ-027 A single flit routes like a head but does not set lock.
REQ-028 A head arriving while lock=1 is treated as an implicit tail: it overwrites route_reg and stays locked.
REQ-029 A body or tail flit arriving with lock=0 is an orphan: it is dropped (out_valid=0, drop_pulse=1 for one cycle) and the FSM proceeds as for a transfer with out_ready=1.
REQ-030 rd_en is never asserted when fifo_empty=1.
REQ-031 out_port = 0 whenever out_valid = 0.

Reset
REQ-032 While rst_n=1: state=IDLE, rd_en=0, out_valid=0, out_port=0, drop_pulse=0, lock=0, route_reg=0.
REQ-033 Reset mid-packet discards the held flit and the lock; the first flit read after release must be a head or single, otherwise it is dropped as an orphan.

Configuration
REQ-034 Macro XY_ROUTE_STATS_EN, when defined, adds 16-bit outputs flit_cnt (transfers) and drop_cnt (orphans); both saturate at 0xFFFF and reset to 0.
REQ-035 Without XY_ROUTE_STATS_EN, these ports and counters do not exist and all other behaviour is identical.

Structure
REQ-036 The shared package noc_pkg holds the flit-type encodings, port one-hot constants (PORT_E=5'b00001 through PORT_L=5'b10000) and the FSM state encoding.
REQ-037 A combinational sub-module xy_route_calc (dest_x, dest_y -> one-hot port) is instantiated once.

Verification
REQ-038 LOCAL=(2,1), out_ready=1; single flits to (3,1), (0,3), (2,3), (2,0), (2,1) -> out_port E, W, N, S, L respectively.
REQ-039 A head to (3,0), 2 body flits and a tail, all queued -> 4 consecutive cycles of out_valid with out_port=E, rd_en high for 4 consecutive cycles, lock clear after the tail.
REQ-040 As REQ-039 with out_ready=0 for 3 cycles on body #1 -> out_flit and out_port held; no rd_en during the stall; no flit lost or duplicated.
REQ-041 A body flit with lock=0 -> out_valid stays 0, drop_pulse=1 for 1 cycle, drop_cnt=1 (stats build).
REQ-042 Reset pulsed after the head and 1 body flit -> outputs go to their reset values; the next tail is dropped; the following single to (2,1) routes to L.
REQ-043 FIFO empty throughout -> rd_en=0 and out_valid=0 for 20 cycles.
